// File: rtl/uart_word_loader.sv
// uart_word_loader: packs UART bytes (MSB first) into 32-bit words and writes
// them to consecutive instruction-memory addresses. Loading ends on END_WORD
// or when the last address has been written, which releases the processor.
// A partial word is discarded if no byte arrives for TIMEOUT_TICKS s_ticks.
module uart_word_loader #(
  parameter int          ADDR_W        = 10,
  parameter int          TIMEOUT_TICKS = 640,
  parameter logic [31:0] END_WORD      = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              s_tick,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              MIPS_enable,
  output logic              frame_err,
  output logic              mem_full
);

  localparam int                TCNT_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state, state_next;
  logic [1:0]        byte_cnt;
  logic [23:0]       held;      // up to three bytes already received
  logic [TCNT_W-1:0] tcnt;
  logic [ADDR_W-1:0] addr;
  logic              accept;    // this cycle's byte is taken into the word
  logic              tout;      // partial word is discarded this cycle
  logic [31:0]       word_full;

  // The fourth byte completes the word combinationally so it can be tested
  // against END_WORD and registered into mem_wdata on the same edge.
  assign word_full = {held, rx_data};

  // Next-state decode; rx_done takes priority over a coincident timeout.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_next = state;
    accept     = 1'b0;
    tout       = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done) begin
          accept     = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_done) begin
          accept = 1'b1;
          if (byte_cnt == 2'd3)
            state_next = (word_full == END_WORD) ? DONE : WRITE;
        end else if (s_tick && tcnt == TCNT_MAX) begin
          tout       = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        // A full memory ends loading even if a new byte is arriving.
        if (addr == ADDR_MAX) begin
          state_next = DONE;
        end else if (rx_done) begin
          accept     = 1'b1;
          state_next = COLLECT;
        end else begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // State, byte assembly, timeout counter and write address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      held     <= 24'd0;
      tcnt     <= '0;
      addr     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state <= state_next;
      if (accept) begin
        held     <= {held[15:0], rx_data};
        byte_cnt <= byte_cnt + 2'd1;  // wraps 3 -> 0 as the word completes
        tcnt     <= '0;
      end else if (tout) begin
        byte_cnt <= 2'd0;
        tcnt     <= '0;
      end else if (state == COLLECT && s_tick) begin
        tcnt <= tcnt + TCNT_W'(1);
      end
      if (state == WRITE && addr != ADDR_MAX)
        addr <= addr + ADDR_W'(1);
    end
  end

  // Registered outputs, loaded on the edge that enters the matching state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
      MIPS_enable <= 1'b0;
      frame_err   <= 1'b0;
      mem_full    <= 1'b0;
    end else begin
      mem_we      <= (state_next == WRITE);
      MIPS_enable <= (state_next == DONE);
      frame_err   <= tout;
      if (state_next == WRITE) begin
        mem_wdata <= word_full;
        mem_addr  <= addr;
      end
      if (state == WRITE && addr == ADDR_MAX)
        mem_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader: a scoreboard queue holds the
// expected memory writes, popped by a monitor whenever mem_we is seen.
module tb_uart_word_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        s_tick = 1'b0;

  logic        a_we, a_en, a_ferr, a_full;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_we, b_en, b_ferr, b_full;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  q_a[$];
  wr_t  q_b[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ferr_cnt = 0;
  int   exp_addr = 0;
  bit   b_active = 1'b0;

  always #5 clk = ~clk;

  uart_word_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .s_tick(s_tick),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .MIPS_enable(a_en), .frame_err(a_ferr), .mem_full(a_full)
  );

  uart_word_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .s_tick(s_tick),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .MIPS_enable(b_en), .frame_err(b_ferr), .mem_full(b_full)
  );

  // Monitor for the wide instance: every write strobe must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_ferr) ferr_cnt++;
      if (a_we) begin
        wr_t e;
        n_checks++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write_a: got addr=%0d data=%h, required no write", a_addr, a_wdata);
        end else begin
          e = q_a.pop_front();
          if (a_addr !== e.addr || a_wdata !== e.data) begin
            n_fail++;
            $display("FAIL write_a: got addr=%0d data=%h, required addr=%0d data=%h",
                     a_addr, a_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  // Monitor for the 4-word instance, active only in its own test.
  always @(negedge clk) begin
    if (!reset && b_active && b_we) begin
      wr_t e;
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write_b: got addr=%0d data=%h, required no write", b_addr, b_wdata);
      end else begin
        e = q_b.pop_front();
        if ({8'd0, b_addr} !== e.addr || b_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write_b: got addr=%0d data=%h, required addr=%0d data=%h",
                   b_addr, b_wdata, e.addr, e.data);
        end
      end
    end
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit writes, input bit to_b);
    wr_t e;
    if (writes) begin
      e.addr = 10'(exp_addr);
      e.data = w;
      q_a.push_back(e);
      if (to_b) q_b.push_back(e);
      exp_addr++;
    end
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic ticks(input int n);
    s_tick = 1'b1;
    repeat (n) @(negedge clk);
    s_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset(input string tag);
    reset = 1'b1;
    rx_done = 1'b0;
    s_tick = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_we, a_en, a_ferr, a_full} !== 4'b0 || a_addr !== 10'd0 || a_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL %s: got we=%b en=%b ferr=%b full=%b addr=%0d data=%h, required all zero",
               tag, a_we, a_en, a_ferr, a_full, a_addr, a_wdata);
    end
    reset = 1'b0;
    q_a.delete();
    q_b.delete();
    exp_addr = 0;
    ferr_cnt = 0;
    @(negedge clk);
    check_bit({tag, "_no_we_after"}, a_we, 1'b0);
  endtask

  task automatic test_single_word();
    send_word(32'h1234_5678, 1'b1, 1'b0);
    check_bit("single_we_latency", a_we, 1'b1);
    idle(1);
    check_bit("single_we_one_cycle", a_we, 1'b0);
    n_checks++;
    if (a_wdata !== 32'h1234_5678 || a_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL single_hold: got addr=%0d data=%h, required addr=0 data=12345678", a_addr, a_wdata);
    end
    check_int("single_pending", q_a.size(), 0);
  endtask

  task automatic test_back_to_back();
    // Byte 0 of the second word lands in the WRITE cycle of the first.
    send_word(32'hCAFE_0001, 1'b1, 1'b0);
    send_word(32'hCAFE_0002, 1'b1, 1'b0);
    idle(2);
    check_int("b2b_pending", q_a.size(), 0);
  endtask

  task automatic test_end_word();
    send_word(32'h0000_0001, 1'b1, 1'b0);
    idle(3);
    send_word(32'hA5A5_5A5A, 1'b1, 1'b0);
    send_word(32'h0BAD_F00D, 1'b1, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
    check_bit("end_mips_enable", a_en, 1'b1);
    check_bit("end_no_write", a_we, 1'b0);
    send_word(32'h1111_2222, 1'b0, 1'b0);
    idle(5);
    check_bit("end_mips_held", a_en, 1'b1);
    check_int("end_pending", q_a.size(), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_bit("end_reset_clears_mips", a_en, 1'b0);
  endtask

  task automatic test_timeout();
    send_byte(8'hAA);
    send_byte(8'hBB);
    ticks(639);
    check_int("timeout_early", ferr_cnt, 0);
    ticks(1);
    check_bit("timeout_ferr_pulse", a_ferr, 1'b1);
    idle(4);
    check_int("timeout_ferr_count", ferr_cnt, 1);
    send_word(32'h0102_0304, 1'b1, 1'b0);
    idle(2);
    check_int("timeout_pending", q_a.size(), 0);
  endtask

  task automatic test_timeout_race();
    wr_t e;
    send_byte(8'hAA);
    send_byte(8'hBB);
    ticks(639);
    e.addr = 10'(exp_addr);
    e.data = 32'hAABB_CCDD;
    q_a.push_back(e);
    exp_addr++;
    s_tick = 1'b1;
    send_byte(8'hCC);
    s_tick = 1'b0;
    idle(3);
    check_int("race_no_ferr", ferr_cnt, 0);
    send_byte(8'hDD);
    idle(2);
    check_int("race_pending", q_a.size(), 0);
  endtask

  task automatic test_mid_word_reset();
    send_byte(8'h55);
    send_byte(8'h66);
    test_reset("midword_reset");
    send_word(32'h1122_3344, 1'b1, 1'b0);
    idle(2);
    check_int("midword_pending", q_a.size(), 0);
  endtask

  task automatic test_mem_full();
    b_active = 1'b1;
    for (int i = 0; i < 4; i++) send_word(32'h5000_0000 + 32'(i), 1'b1, 1'b1);
    idle(1);
    check_bit("full_flag", b_full, 1'b1);
    check_bit("full_mips", b_en, 1'b1);
    check_bit("full_wide_not_full", a_full, 1'b0);
    send_word(32'h6000_0000, 1'b1, 1'b0);
    idle(3);
    check_int("full_addr_hold", int'(b_addr), 3);
    check_int("full_pending_b", q_b.size(), 0);
    check_int("full_pending_a", q_a.size(), 0);
    b_active = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset("reset");
    test_single_word();
    test_back_to_back();
    test_reset("reset2");
    test_end_word();
    test_reset("reset3");
    test_timeout();
    test_reset("reset4");
    test_timeout_race();
    test_mid_word_reset();
    test_reset("reset5");
    test_mem_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
